// File: rtl/frame_buffer_arbiter.sv
// Arbiter in front of a single frame_cell: display reads, a full-frame clear engine and
// the renderer's pixel writes share one port, at most one operation per cycle.
module frame_buffer_arbiter #(
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480,
   parameter int PIX_W   = 3,
   parameter int XW      = 10,
   parameter int YW      = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_req_valid,
   output logic             wr_req_ready,
   input  logic [XW-1:0]    wr_x,
   input  logic [YW-1:0]    wr_y,
   input  logic [PIX_W-1:0] wr_pixel,
   output logic             wr_oob,
   input  logic             disp_rd_valid,
   input  logic [XW-1:0]    disp_x,
   input  logic [YW-1:0]    disp_y,
   output logic [PIX_W-1:0] disp_pixel,
   output logic             disp_pixel_valid,
   input  logic             clear_start,
   input  logic [PIX_W-1:0] clear_color,
   output logic             clear_busy,
   output logic             clear_done,
   output logic             fc_write_enable,
   output logic [XW-1:0]    fc_write_frame_width,
   output logic [YW-1:0]    fc_write_frame_height,
   output logic [PIX_W-1:0] fc_write_data,
   output logic             fc_read_enable,
   output logic [XW-1:0]    fc_read_frame_width,
   output logic [YW-1:0]    fc_read_frame_height,
   input  logic [PIX_W-1:0] fc_read_data
);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t           state, state_nxt;
   logic [XW-1:0]    cx, cx_nxt;
   logic [YW-1:0]    cy, cy_nxt;
   logic [PIX_W-1:0] clr_color;

   logic wr_fire, wr_in, disp_in, clr_grant, clr_last;
   logic vld_p0, rd_oob_p0, rd_oob_p1;

   function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return (int'(x) < FRAME_W) && (int'(y) < FRAME_H);
   endfunction

   assign wr_req_ready = rst_n & (state == IDLE) & ~disp_rd_valid;
   assign wr_fire      = wr_req_valid & wr_req_ready;
   assign wr_in        = in_range(wr_x, wr_y);
   assign disp_in      = in_range(disp_x, disp_y);
   // Display owns the port whenever it asks, so clear only advances on display-free cycles.
   assign clr_grant    = (state == CLEAR) & ~disp_rd_valid;
   assign clr_last     = (cx == XW'(FRAME_W - 1)) && (cy == YW'(FRAME_H - 1));

   assign clear_busy   = (state == CLEAR);
   assign clear_done   = (state == DONE);

   always_comb begin
      state_nxt = state;
      cx_nxt    = cx;
      cy_nxt    = cy;
      case (state)
         IDLE: begin
            if (clear_start) begin
               state_nxt = CLEAR;
               cx_nxt    = '0;
               cy_nxt    = '0;
            end
         end
         CLEAR: begin
            if (clr_grant) begin
               if (clr_last) begin
                  state_nxt = DONE;
               end else if (cx == XW'(FRAME_W - 1)) begin
                  cx_nxt = '0;
                  cy_nxt = cy + YW'(1);
               end else begin
                  cx_nxt = cx + XW'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cx        <= '0;
         cy        <= '0;
         clr_color <= '0;
      end else begin
         state <= state_nxt;
         cx    <= cx_nxt;
         cy    <= cy_nxt;
         if (state == IDLE && clear_start) clr_color <= clear_color;
      end
   end

   // Stage p0: grant registered onto the frame_cell port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fc_write_enable       <= 1'b0;
         fc_write_frame_width  <= '0;
         fc_write_frame_height <= '0;
         fc_write_data         <= '0;
         fc_read_enable        <= 1'b0;
         fc_read_frame_width   <= '0;
         fc_read_frame_height  <= '0;
         wr_oob                <= 1'b0;
         vld_p0                <= 1'b0;
         rd_oob_p0             <= 1'b0;
      end else begin
         if (clr_grant) begin
            fc_write_enable       <= 1'b1;
            fc_write_frame_width  <= cx;
            fc_write_frame_height <= cy;
            fc_write_data         <= clr_color;
         end else if (wr_fire && wr_in) begin
            fc_write_enable       <= 1'b1;
            fc_write_frame_width  <= wr_x;
            fc_write_frame_height <= wr_y;
            fc_write_data         <= wr_pixel;
         end else begin
            fc_write_enable       <= 1'b0;
            fc_write_frame_width  <= '0;
            fc_write_frame_height <= '0;
            fc_write_data         <= '0;
         end
         fc_read_enable       <= disp_rd_valid & disp_in;
         fc_read_frame_width  <= (disp_rd_valid & disp_in) ? disp_x : '0;
         fc_read_frame_height <= (disp_rd_valid & disp_in) ? disp_y : '0;
         wr_oob               <= wr_fire & ~wr_in;
         vld_p0               <= disp_rd_valid;
         rd_oob_p0            <= disp_rd_valid & ~disp_in;
      end
   end

   // Stage p1: frame_cell read data returns; out-of-range reads report zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_pixel_valid <= 1'b0;
         rd_oob_p1        <= 1'b0;
      end else begin
         disp_pixel_valid <= vld_p0;
         rd_oob_p1        <= rd_oob_p0;
      end
   end

   assign disp_pixel = (disp_pixel_valid & ~rd_oob_p1) ? fc_read_data : '0;

endmodule
